// File: rtl/fir_pkg.sv
// Sample types and Q1.15 limits shared by the FIR stage and its downstream blocks.
package fir_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t Q15_MAX = sample_t'(16'sh7FFF);
    localparam sample_t Q15_MIN = sample_t'(16'sh8000);

endpackage

// File: rtl/sample_decim_fifo_sync_fifo.sv
// Synchronous first-word fall-through FIFO with a registered head and a level counter;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // The head register is loaded from the slot that will be at the front after this
    // edge; a word being written into that same slot is forwarded straight from din_i.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
        head_d = head_q;
        if (level_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = head_q;
    assign level_o = level_q;

endmodule

// File: rtl/sample_decim_fifo.sv
// Decimates the FIR output stream by DECIM and buffers kept samples for a valid/ready consumer.
// Define DECIM_AVG_EN to push the rounded mean of each DECIM-sample window instead of its first sample.
module sample_decim_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       valid_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [LVL_W-1:0]           level,
    output logic                       overflow
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            overflow_q, overflow_d;
    logic            push;
    sample_t         push_data;
    logic            fifo_full, fifo_empty;
    logic            pop;
    logic [SAMPLE_W-1:0] fifo_dout;

    always_comb begin
        phase_d = phase_q;
        if (valid_in) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
    end

`ifdef DECIM_AVG_EN
    localparam int unsigned K     = $clog2(DECIM);
    localparam int unsigned ACC_W = SAMPLE_W + K;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] RND = SUM_W'((1 << K) >> 1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum;

    // Taking bits [K+SAMPLE_W-1:K] of the rounded sum is the arithmetic shift by K.
    always_comb begin
        sum       = SUM_W'(acc_q) + SUM_W'(sample_in) + RND;
        push      = valid_in && (phase_q == PH_LAST);
        push_data = sum[K +: SAMPLE_W];
        acc_d     = acc_q;
        if (valid_in) begin
            acc_d = (phase_q == PH_LAST) ? '0 : acc_q + ACC_W'(sample_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        push      = valid_in && (phase_q == '0);
        push_data = sample_in;
    end
`endif

    assign pop        = valid_out && ready_out;
    assign overflow_d = overflow_q | (push && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign sample_out = $signed(fifo_dout);
    assign valid_out  = !fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sample_decim_fifo.sv
// Directed bench for sample_decim_fifo with a queue scoreboard; honours DECIM_AVG_EN.
module tb_sample_decim_fifo;

    localparam int DECIM = 4;
    localparam int DEPTH = 8;
    localparam int K     = $clog2(DECIM);
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef DECIM_AVG_EN
    localparam int PUSH_PH = DECIM - 1;
`else
    localparam int PUSH_PH = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic signed [15:0]  sample_in;
    logic                valid_in;
    logic signed [15:0]  sample_out;
    logic                valid_out;
    logic                ready_out;
    logic [LVL_W-1:0]    level;
    logic                overflow;

    sample_decim_fifo #(
        .DECIM (DECIM),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .valid_in   (valid_in),
        .sample_out (sample_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_q[$];
    int m_level, m_phase, m_acc, m_last, m_ovf;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the DUT state before the edge, then advance the model across it.
    task automatic step(input bit r, input bit v, input int s, input bit rdy);
        bit pop, keep;
        int val;
        rst       = r;
        valid_in  = v;
        sample_in = 16'(s);
        ready_out = rdy;
        @(negedge clk);
        chk("level", {28'd0, level}, m_level);
        chk("level_bound", 32'(level <= LVL_W'(DEPTH)), 1);
        chk("valid_out", {31'd0, valid_out}, 32'(m_level != 0));
        chk("overflow", {31'd0, overflow}, m_ovf);
        if (m_level != 0) chk("sample_out", 32'(sample_out), exp_q[0]);
        else              chk("sample_hold", 32'(sample_out), m_last);
        if (r) begin
            exp_q.delete();
            m_level = 0; m_phase = 0; m_acc = 0; m_last = 0; m_ovf = 0;
        end else begin
            pop  = (m_level != 0) && rdy;
            keep = 1'b0;
            val  = 0;
            if (v) begin
`ifdef DECIM_AVG_EN
                if (m_phase == DECIM - 1) begin
                    keep  = 1'b1;
                    val   = (m_acc + s + DECIM / 2) >>> K;
                    m_acc = 0;
                end else begin
                    m_acc = m_acc + s;
                end
`else
                if (m_phase == 0) begin
                    keep = 1'b1;
                    val  = s;
                end
`endif
                m_phase = (m_phase + 1) % DECIM;
            end
            if (pop) begin
                m_last  = exp_q.pop_front();
                m_level = m_level - 1;
            end
            if (keep) begin
                if (m_level < DEPTH) begin
                    exp_q.push_back(val);
                    m_level = m_level + 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One full window of DECIM samples of constant value; ready only on the pushing sample if asked.
    task automatic window(input int val, input bit rdy_all, input bit rdy_push);
        for (int p = 0; p < DECIM; p++) begin
            step(1'b0, 1'b1, val, rdy_all || (rdy_push && (p == PUSH_PH)));
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; sample_in = '0; ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_level = 0; m_phase = 0; m_acc = 0; m_last = 0; m_ovf = 0;

        // reset must win over a simultaneous valid sample
        step(1'b1, 1'b1, 123, 1'b1);

        // basic decimation, continuous ramp
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i, 1'b1);
        repeat (2) step(1'b0, 1'b0, 0, 1'b1);

        // input gaps
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, i, 1'b1);
            step(1'b0, 1'b0, 0, 1'b1);
        end
        repeat (2) step(1'b0, 1'b0, 0, 1'b1);

        // fill to full, then push and pop in the same cycle
        for (int k = 0; k < DEPTH; k++) window(10 * (k + 1), 1'b0, 1'b0);
        window(100, 1'b0, 1'b1);
        repeat (DEPTH + 2) step(1'b0, 1'b0, 0, 1'b1);

        // overflow: nine kept samples into an eight-deep stalled FIFO
        for (int k = 1; k <= 9; k++) window(k, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        repeat (DEPTH + 2) step(1'b0, 1'b0, 0, 1'b1);

        // reset mid-operation with a partial window in flight
        for (int k = 0; k < 4; k++) window(20 + k, 1'b0, 1'b0);
        step(1'b0, 1'b1, 24, 1'b0);
        step(1'b0, 1'b1, 24, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        window(55, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 0, 1'b1);

        // averaging windows (keep-first in the default build)
        step(1'b0, 1'b1, 1, 1'b1);
        step(1'b0, 1'b1, 2, 1'b1);
        step(1'b0, 1'b1, 3, 1'b1);
        step(1'b0, 1'b1, 4, 1'b1);
        step(1'b0, 1'b1, -1, 1'b1);
        step(1'b0, 1'b1, -2, 1'b1);
        step(1'b0, 1'b1, -2, 1'b1);
        step(1'b0, 1'b1, -2, 1'b1);
        window(32767, 1'b1, 1'b0);
        window(-32768, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 0, 1'b1);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_decim_fifo.md
Name: sample_decim_fifo

Overview:
- Downstream neighbour of the FIR stage: consumes its streaming Q1.15 output (sample/valid; the FIR has no backpressure).
- Decimates by DECIM and buffers kept samples in a small FIFO.
- Presents a valid/ready stream to the next consumer (DAC serializer, DMA, etc.).
- Reports overflow when the consumer stalls longer than the FIFO can absorb.

Parameters:
- DECIM, 4: decimation factor; power of two, 1..16 (DECIM=1 is pass-through).
- DEPTH, 8: FIFO entries; power of two, 2..64.
- LVL_W, $clog2(DEPTH)+1: level counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- sample_in  in  16  signed Q1.15 sample from the FIR.
- valid_in  in  1  sample_in qualifier; no ready back to the source, input never stalls.
- sample_out  out  16  signed Q1.15 head-of-FIFO sample.
- valid_out  out  1  high when the FIFO is non-empty.
- ready_out  in  1  consumer ready; pop when valid_out && ready_out.
- level  out  LVL_W  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a kept sample is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high):
  - phase=0, FIFO empty, level=0, valid_out=0, sample_out=0, overflow=0, accumulator=0.
  - Reset wins over any simultaneous valid_in or pop.
  - Reset mid-operation discards FIFO contents and partial decimation phase.
- Phase counter:
  - Advances by 1 mod DECIM on each valid_in.
  - Holds when valid_in=0; gaps in valid_in do not disturb decimation.
- Keep rule (macro off): the sample with valid_in && phase==0 is kept, i.e. the 1st, (DECIM+1)th, and so on.
- Push and latency:
  - A kept sample is pushed in the same cycle.
  - If the FIFO was empty, valid_out=1 and sample_out=that sample on the next cycle (latency 1).
- FIFO:
  - First-word fall-through; sample_out is a registered head.
  - sample_out holds its last value when empty.
  - Pop happens on valid_out && ready_out.
- Full with push, no pop: sample dropped, overflow<=1, contents and level unchanged.
- Full with push and pop in the same cycle: both occur, no overflow, level stays DEPTH.
- Empty with pop attempted: impossible, since valid_out=0.
- Empty with push: level goes 0→1.
- Push and pop in the same cycle (not full): level unchanged, head advances, new tail written.
- Pointers: log2(DEPTH)-bit, natural wrap; full/empty derived from the level counter.
- overflow: cleared only by rst.
- Invariants (for the formal/bench checker):
  - valid_out == (level!=0).
  - level<=DEPTH.
  - Output order equals keep order.

Optional Feature:
- Macro: DECIM_AVG_EN.
- Defined: instead of keeping one sample per phase, accumulate all DECIM samples of a phase window.
  - Accumulator is signed, 16+log2(DECIM) bits.
  - On the valid_in with phase==DECIM-1, push the mean = (acc + sample_in + 2^(k-1)) >>> k, where k=log2(DECIM): arithmetic shift, round half up.
  - The result is always within Q1.15 range, so no saturation is needed.
  - The accumulator clears on the same cycle.
  - Latency: 1 cycle after the last sample of the window.
  - DECIM=1 gives pass-through.
- Undefined: no accumulator logic is synthesised; the keep-first rule applies.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W=16.
  - typedef signed sample_t [SAMPLE_W-1:0].
  - Q15_MAX/Q15_MIN constants, reused with the FIR stage.
- One natural sub-module: sync_fifo, parameterised by width and depth.
  - Ports: push/pop/full/empty/level.
  - Registered head output; simultaneous push+pop-at-full accepted.
- Decimation/averaging stays in the top module.

Test Plan:
- Basic decimation: DECIM=4, ready_out=1, valid_in continuous, ramp 0..15 → outputs 0,4,8,12, each 1 cycle after its input; level never exceeds 1.
- Input gaps: DECIM=4, valid_in toggling 1/0 with ramp 0..7 → outputs 0,4.
- Overflow: DECIM=1, DEPTH=8, ready_out=0, push 1..9 → level=8, overflow=1 after the 9th push.
  - Then ready_out=1 → outputs 1..8; the 9th sample is lost; overflow stays 1.
- Full with simultaneous push+pop: fill to 8, then push 100 while ready_out=1 → no overflow, level=8, 100 emitted last.
- Reset mid-operation: level=5, phase=2, assert rst for 1 cycle.
  - Next cycle: valid_out=0, level=0, overflow=0, sample_out=0.
  - Next kept sample is the first valid_in after reset.
- DECIM_AVG_EN, DECIM=4:
  - Inputs 1,2,3,4 → output 3.
  - Inputs -1,-2,-2,-2 → output -2.
  - Inputs 32767×4 → 32767.
  - Inputs -32768×4 → -32768.
